// File: rtl/sprite_pkg.sv
// Shared constants, register offsets and attribute type for the sprite renderer.
package sprite_pkg;

  // Timing constants (controller counts of the first visible pixel/line)
  localparam int HBP_PLUS1 = 145;
  localparam int VBP_PLUS1 = 36;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SPR_SIZE  = 16;

  // Per-sprite register offsets within the 5-bit offset field
  localparam logic [4:0] OFF_CTRL  = 5'd0;
  localparam logic [4:0] OFF_COLOR = 5'd1;
  localparam logic [4:0] OFF_BMP   = 5'd16;

  typedef struct packed {
    logic        en;
    logic [8:0]  y;
    logic [9:0]  x;
    logic [23:0] colour;
  } sprite_attr_t;

  localparam sprite_attr_t ATTR_RESET = sprite_attr_t'(44'd0);

  // True when a signed offset falls inside one sprite cell (0..15)
  function automatic logic in_cell(input logic signed [10:0] d);
    return (d >= 11'sd0) && (d < 11'(SPR_SIZE));
  endfunction

endpackage

// File: rtl/sprite_unit.sv
// One sprite: shadow/active attributes, bitmap rows, stage-1 hit and
// stage-2 opaque evaluation.
module sprite_unit
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_sel,
  input  logic [4:0]         wr_off,
  input  logic [23:0]        wr_data,
  input  logic               commit,
  input  logic               visible,
  input  logic signed [10:0] xl,
  input  logic signed [10:0] yl,
  output logic               opaque,
  output logic [23:0]        colour
);

  sprite_attr_t       shadow_r;
  sprite_attr_t       active_r;
  logic [15:0]        bitmap_r [SPR_SIZE];
  logic signed [10:0] dx_s;
  logic signed [10:0] dy_s;
  logic               hit_s;
  logic               hit_r;
  logic [3:0]         dx_r;
  logic [3:0]         dy_r;
  logic [15:0]        row_s;

  // Shadow copy captures ctrl/colour writes; it never affects rendering directly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r <= ATTR_RESET;
    end else if (wr_sel) begin
      case (wr_off)
        OFF_CTRL: begin
          shadow_r.en <= wr_data[19];
          shadow_r.y  <= wr_data[18:10];
          shadow_r.x  <= wr_data[9:0];
        end
        OFF_COLOR: shadow_r.colour <= wr_data;
        default:   shadow_r <= shadow_r;
      endcase
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active copy only changes at the frame boundary so a frame never tears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_r <= ATTR_RESET;
    end else if (commit) begin
      active_r <= shadow_r;
    end else begin
      active_r <= active_r;
    end
  end

  // Bitmap rows are written straight through, offsets 16..31 select the row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < SPR_SIZE; r++) begin
        bitmap_r[r] <= 16'd0;
      end
    end else if (wr_sel && wr_off[4]) begin
      bitmap_r[wr_off[3:0]] <= wr_data[15:0];
    end else begin
      for (int r = 0; r < SPR_SIZE; r++) begin
        bitmap_r[r] <= bitmap_r[r];
      end
    end
  end

  assign dx_s  = xl - $signed({1'b0, active_r.x});
  assign dy_s  = yl - $signed({2'b00, active_r.y});
  assign hit_s = active_r.en & visible & in_cell(dx_s) & in_cell(dy_s);

  // Stage 1: register the hit flag and the in-cell coordinates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_r <= 1'b0;
      dx_r  <= 4'd0;
      dy_r  <= 4'd0;
    end else begin
      hit_r <= hit_s;
      dx_r  <= dx_s[3:0];
      dy_r  <= dy_s[3:0];
    end
  end

  // Stage 2 lookup: bit 15 of a row is the leftmost column
  assign row_s  = bitmap_r[dy_r];
  assign opaque = hit_r & row_s[4'd15 - dx_r];
  assign colour = active_r.colour;

endmodule

// File: rtl/sprite_renderer.sv
// Sprite compositor feeding the VGA controller's rin/gin/bin.
// Two-clock pipeline; coordinates are computed LOOKAHEAD pixels ahead.
// Optional macro SPRITE_COLLIDE_EN adds the per-sprite collide output.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = 4,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  parameter int          LOOKAHEAD   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  counterH,
  input  logic [9:0]  counterV,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [23:0] wr_data,
  output logic [7:0]  rout,
  output logic [7:0]  gout,
  output logic [7:0]  bout,
  output logic        frame_start
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic [NUM_SPRITES-1:0] collide
`endif
);

  localparam logic signed [10:0] X_OFFSET = 11'(HBP_PLUS1 - LOOKAHEAD);
  localparam logic signed [10:0] Y_OFFSET = 11'(VBP_PLUS1);
  localparam logic signed [10:0] X_LIMIT  = 11'(H_ACTIVE);
  localparam logic signed [10:0] Y_LIMIT  = 11'(V_ACTIVE);

  logic signed [10:0]     xl_s;
  logic signed [10:0]     yl_s;
  logic                   visible_s;
  logic                   commit_s;
  logic [NUM_SPRITES-1:0] wr_sel_s;
  logic [NUM_SPRITES-1:0] opaque_s;
  logic [23:0]            colour_s [NUM_SPRITES];
  logic [23:0]            pix_s;
  logic [23:0]            rgb_r;
  logic                   frame_start_r;

  assign xl_s      = $signed({1'b0, counterH}) - X_OFFSET;
  assign yl_s      = $signed({1'b0, counterV}) - Y_OFFSET;
  assign visible_s = (xl_s >= 11'sd0) && (xl_s < X_LIMIT) &&
                     (yl_s >= 11'sd0) && (yl_s < Y_LIMIT);
  assign commit_s  = (counterH == 10'd0) && (counterV == 10'd0);

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_spr
    assign wr_sel_s[s] = wr_en && (wr_addr[7:5] == 3'(s));

    sprite_unit u_spr (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_sel  (wr_sel_s[s]),
      .wr_off  (wr_addr[4:0]),
      .wr_data (wr_data),
      .commit  (commit_s),
      .visible (visible_s),
      .xl      (xl_s),
      .yl      (yl_s),
      .opaque  (opaque_s[s]),
      .colour  (colour_s[s])
    );
  end

  // Priority mux: scan from lowest priority up so index 0 wins
  always_comb begin
    pix_s = BG_COLOR;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      pix_s = opaque_s[s] ? colour_s[s] : pix_s;
    end
  end

  // Stage 2 output register and frame_start pulse one cycle after commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_r         <= 24'd0;
      frame_start_r <= 1'b0;
    end else begin
      rgb_r         <= pix_s;
      frame_start_r <= commit_s;
    end
  end

  assign rout        = rgb_r[23:16];
  assign gout        = rgb_r[15:8];
  assign bout        = rgb_r[7:0];
  assign frame_start = frame_start_r;

`ifdef SPRITE_COLLIDE_EN
  logic [NUM_SPRITES-1:0] clash_s;
  logic [NUM_SPRITES-1:0] acc_r;
  logic [NUM_SPRITES-1:0] collide_r;

  // A sprite clashes when it and at least one other sprite are opaque together
  always_comb begin
    clash_s = {NUM_SPRITES{1'b0}};
    for (int s = 0; s < NUM_SPRITES; s++) begin
      clash_s[s] = opaque_s[s] & (|(opaque_s & ~(NUM_SPRITES'(1) << s)));
    end
  end

  // Sticky per-frame accumulator, published and cleared at the frame boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r     <= {NUM_SPRITES{1'b0}};
      collide_r <= {NUM_SPRITES{1'b0}};
    end else if (commit_s) begin
      acc_r     <= {NUM_SPRITES{1'b0}};
      collide_r <= acc_r;
    end else begin
      acc_r     <= acc_r | clash_s;
      collide_r <= collide_r;
    end
  end

  assign collide = collide_r;
`endif

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed self-checking bench for sprite_renderer.
module tb_sprite_renderer;

  logic        clk;
  logic        reset_n;
  logic [9:0]  counterH;
  logic [9:0]  counterV;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  rout;
  logic [7:0]  gout;
  logic [7:0]  bout;
  logic        frame_start;
`ifdef SPRITE_COLLIDE_EN
  logic [3:0]  collide;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [9:0] park_v = 10'd10;

  sprite_renderer #(.NUM_SPRITES(4), .BG_COLOR(24'h000000), .LOOKAHEAD(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .counterH    (counterH),
    .counterV    (counterV),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rout        (rout),
    .gout        (gout),
    .bout        (bout),
    .frame_start (frame_start)
`ifdef SPRITE_COLLIDE_EN
    ,
    .collide     (collide)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic park();
    counterH = 10'd10;
    counterV = park_v;
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Present one counter pair, then check the colour two clocks later
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [23:0] exp, input string tag);
    counterH = h; counterV = v;
    @(posedge clk); #1;
    park();
    @(posedge clk); #1;
    chk(tag, {rout, gout, bout}, exp);
  endtask

  task automatic commit_frame();
    counterH = 10'd0; counterV = 10'd0;
    @(posedge clk); #1;
    park();
    chk("frame_start_hi", {23'd0, frame_start}, 24'd1);
    @(posedge clk); #1;
    chk("frame_start_lo", {23'd0, frame_start}, 24'd0);
  endtask

  function automatic logic [23:0] ctrl(input logic en, input int y, input int x);
    return {4'd0, en, 9'(y), 10'(x)};
  endfunction

  initial begin
    reset_n = 1'b0; counterH = 10'd0; counterV = 10'd0;
    wr_en = 1'b0; wr_addr = 8'd0; wr_data = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", {rout, gout, bout}, 24'd0);
    chk("reset_fs", {23'd0, frame_start}, 24'd0);
    counterH = 10'd5; counterV = 10'd3;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      counterH = 10'(240 + i); counterV = 10'd86;
      @(posedge clk); #1;
      chk("run_rgb", {rout, gout, bout}, 24'd0);
      chk("run_no_fs", {23'd0, frame_start}, 24'd0);
    end
    park();

    // Sprite 0 at (100,50), red, row0 = 8001
    wr(8'h00, ctrl(1'b1, 50, 100));
    wr(8'h01, 24'hFF0000);
    wr(8'h10, 24'h008001);
    pix(10'd243, 10'd86, 24'h000000, "shadow_not_active");
    commit_frame();
    pix(10'd243, 10'd86, 24'hFF0000, "spr0_col0");
    pix(10'd244, 10'd86, 24'h000000, "spr0_col1_clear");
    pix(10'd258, 10'd86, 24'hFF0000, "spr0_col15");
    pix(10'd259, 10'd86, 24'h000000, "spr0_col16_out");
    pix(10'd243, 10'd87, 24'h000000, "spr0_row1_clear");

    // Sprite 1 green at the same spot, all rows solid for both
    wr(8'h20, ctrl(1'b1, 50, 100));
    wr(8'h21, 24'h00FF00);
    for (int r = 0; r < 16; r++) begin
      wr(8'(8'h10 + r), 24'h00FFFF);
      wr(8'(8'h30 + r), 24'h00FFFF);
    end
    commit_frame();
`ifdef SPRITE_COLLIDE_EN
    chk("collide_none", {20'd0, collide}, 24'd0);
`endif
    pix(10'd250, 10'd90, 24'hFF0000, "priority_spr0");

    // Move sprite 0 mid-frame; must wait for the commit
    park_v = 10'd200; park();
    wr(8'h00, ctrl(1'b1, 50, 300));
    pix(10'd243, 10'd86, 24'hFF0000, "move_pending");
    park_v = 10'd10;
    commit_frame();
`ifdef SPRITE_COLLIDE_EN
    chk("collide_pair", {20'd0, collide}, 24'h000003);
`endif
    pix(10'd243, 10'd86, 24'h00FF00, "moved_spr1_shows");
    pix(10'd443, 10'd86, 24'hFF0000, "moved_spr0_x300");

    // Right-edge clipping with sprite 0 at x=630
    wr(8'h20, ctrl(1'b0, 0, 0));
    wr(8'h00, ctrl(1'b1, 50, 630));
    commit_frame();
`ifdef SPRITE_COLLIDE_EN
    chk("collide_cleared", {20'd0, collide}, 24'd0);
`endif
    pix(10'd773, 10'd86, 24'hFF0000, "clip_x630");
    pix(10'd782, 10'd86, 24'hFF0000, "clip_x639");
    pix(10'd783, 10'd86, 24'h000000, "clip_x640");
    pix(10'd788, 10'd86, 24'h000000, "clip_x645");
    pix(10'd799, 10'd86, 24'h000000, "wrap_h799");
    pix(10'd800, 10'd86, 24'h000000, "wrap_h800");
    pix(10'd143, 10'd87, 24'h000000, "no_wrap_x0");

    // Immediate bitmap update
    wr(8'h00, ctrl(1'b1, 50, 100));
    wr(8'h10, 24'h008001);
    commit_frame();
    pix(10'd244, 10'd86, 24'h000000, "bmp_before");
    wr(8'h10, 24'h00FFFF);
    pix(10'd244, 10'd86, 24'hFF0000, "bmp_immediate");

    // Reset mid-frame clears outputs without waiting for a clock
    counterH = 10'd244; counterV = 10'd86;
    @(posedge clk); #1;
    @(posedge clk); #5;
    chk("pre_reset_rgb", {rout, gout, bout}, 24'hFF0000);
    reset_n = 1'b0;
    #2;
    chk("async_reset_rgb", {rout, gout, bout}, 24'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pix(10'd244, 10'd86, 24'h000000, "post_reset_disabled");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
